// File: rtl/ifetch_pkg.sv
// Shared constants, entry type and sizing helper for the instruction fetch front end.
package ifetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // Width of a counter that must be able to hold the value DEPTH itself.
    function automatic int clog2p1(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding fetched {inst, pc} entries; head is visible combinationally.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int CW   = clog2p1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // A full FIFO may still accept a push when its head leaves in the same cycle.
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count_reg + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited memory requests, stale-response
// dropping on redirect and a response FIFO. Optional macro IFETCH_BYPASS_EN adds a same-cycle bypass.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = clog2p1(DEPTH);

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   resp_pc_reg, resp_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_reg, drop_next;

    logic          accept;
    logic          keep_rsp;
    logic [31:0]   target_pc;
    logic [CW:0]   credit_used;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_in;
    fetch_entry_t  fifo_head;

    assign target_pc   = redirect_pc & ~32'h3;
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};

    // Requests are gated during reset because the credit check alone would already pass.
    assign imem_req  = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_reg;
    assign accept    = imem_req && imem_gnt;

    // Responses landing in a redirect cycle are stale by definition.
    assign keep_rsp  = imem_rvalid && (drop_reg == '0) && !redirect_valid;
    assign fifo_in   = '{inst: imem_rdata, pc: resp_pc_reg};
    assign fifo_pop  = !fifo_empty && !stall && !redirect_valid;

`ifdef IFETCH_BYPASS_EN
    logic bypass;

    assign bypass     = !rst && keep_rsp && fifo_empty;
    assign inst_valid = !fifo_empty || bypass;
    assign inst       = !fifo_empty ? fifo_head.inst : (bypass ? imem_rdata  : '0);
    assign inst_pc    = !fifo_empty ? fifo_head.pc   : (bypass ? resp_pc_reg : '0);
    // A bypassed word only needs buffering when the decoder is stalled.
    assign fifo_push  = keep_rsp && !(bypass && !stall);
`else
    assign inst_valid = !fifo_empty;
    assign inst       = fifo_empty ? '0 : fifo_head.inst;
    assign inst_pc    = fifo_empty ? '0 : fifo_head.pc;
    assign fifo_push  = keep_rsp;
`endif

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg + CW'(accept) - CW'(imem_rvalid);
        drop_next        = drop_reg;
        if (redirect_valid) begin
            fetch_pc_next = target_pc;
            resp_pc_next  = target_pc;
            // Everything still in flight after this cycle belongs to the old path.
            drop_next     = outstanding_reg - CW'(imem_rvalid);
        end else begin
            if (accept)   fetch_pc_next = fetch_pc_reg + PC_INC;
            if (keep_rsp) resp_pc_next  = resp_pc_reg + PC_INC;
            if (imem_rvalid && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    ifetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(64)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .flush    (redirect_valid),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // The credit limit guarantees a push never finds the FIFO full without a pop.
    credit_no_overflow: assert property (@(posedge clk) disable iff (rst)
        fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: in-order memory model plus a scoreboard of accepted fetches.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct {
        logic [31:0] target;
        int          lat;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } redir_vec_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    logic [31:0] acc_log[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = -1;
    int          n_pops = 0;
    int          n_accepts = 0;
    bit          rand_gnt = 1'b0;
    bit          gnt_off = 1'b0;
    bit          arm_first = 1'b0;
    logic [31:0] first_pc;
    logic [31:0] exp_fetch = 32'h0;
    logic        s_valid, s_req;
    logic [31:0] s_inst, s_pc, s_addr;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit stl, input bit redir, input logic [31:0] rpc);
        bit          rsp;
        bit          acc;
        bit          popd;
        logic [31:0] a;
        @(negedge clk);
        stall          = stl;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rvalid    = rsp;
        imem_rdata     = rsp ? (mq[0].addr ^ KEY) : 32'h0;
        imem_gnt       = gnt_off ? 1'b0 : (rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1);
        #1;
        s_valid = inst_valid;
        s_req   = imem_req;
        s_inst  = inst;
        s_pc    = inst_pc;
        s_addr  = imem_addr;
        if (redir) chk_eq("req_in_redirect", 32'(imem_req), 32'd0);
        if (inst_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL stale_inst: got inst_valid pc %h expected none", inst_pc);
            end else begin
                chk_eq("inst_pc", inst_pc, sb[0].pc);
                chk_eq("inst", inst, sb[0].data);
            end
        end
        popd = inst_valid && !stl && !redir;
        acc  = imem_req && imem_gnt;
        a    = imem_addr;
        if (acc) chk_eq("imem_addr", a, exp_fetch);
        if (popd) begin
            n_pops++;
            $display("cyc %0d pop pc=%h inst=%h", cyc, inst_pc, inst);
            if (arm_first) begin
                first_pc  = inst_pc;
                arm_first = 1'b0;
            end
        end
        @(posedge clk);
        if (rsp) void'(mq.pop_front());
        if (popd && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            int d;
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{a, d});
            sb.push_back('{a, a ^ KEY});
            acc_log.push_back(a);
            exp_fetch = exp_fetch + 32'd4;
            n_accepts++;
        end
        if (redir) begin
            sb.delete();
            exp_fetch = rpc & ~32'h3;
        end
        cyc++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        gnt_off = 1'b1;
        while ((sb.size() > 0 || mq.size() > 0) && k < 200) begin
            step(1'b0, 1'b0, 32'h0);
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
        end
        step(1'b0, 1'b0, 32'h0);
        chk_eq("drained_valid", 32'(s_valid), 32'd0);
        gnt_off = 1'b0;
    endtask

    redir_vec_t vecs[4];

    initial begin
        int          k;
        logic [31:0] hold_inst, hold_pc;

        vecs[0] = '{32'h0000_0102, 1, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        vecs[1] = '{32'h0000_0203, 3, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
        vecs[2] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h0000_1001, 2, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008};

        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_eq("rst_req", 32'(imem_req), 32'd0);
        chk_eq("rst_valid", 32'(inst_valid), 32'd0);
        chk_eq("rst_inst", inst, 32'h0);
        chk_eq("rst_inst_pc", inst_pc, 32'h0);
        imem_rvalid = 1'b0;
        rst = 1'b0;

        // Sequential fetch, latency 1
        lat = 1;
        step(1'b0, 1'b0, 32'h0);
        chk_eq("t1_req_c0", 32'(s_req), 32'd1);
        chk_eq("t1_addr_c0", s_addr, 32'h0);
        chk_eq("t1_valid_c0", 32'(s_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0);
        chk_eq("t1_valid_c1", 32'(s_valid), 32'(BYP));
        step(1'b0, 1'b0, 32'h0);
        chk_eq("t1_valid_c2", 32'(s_valid), 32'd1);
        n_pops = 0;
        repeat (10) step(1'b0, 1'b0, 32'h0);
        chk_eq("t1_throughput", 32'(n_pops), 32'd10);

        // Decode stall for 10 cycles
        n_accepts = 0;
        step(1'b1, 1'b0, 32'h0);
        chk_eq("t2_valid_stall", 32'(s_valid), 32'd1);
        hold_inst = s_inst;
        hold_pc   = s_pc;
        repeat (9) begin
            step(1'b1, 1'b0, 32'h0);
            chk_eq("t2_hold_inst", s_inst, hold_inst);
            chk_eq("t2_hold_pc", s_pc, hold_pc);
        end
        chk_eq("t2_req_off", 32'(s_req), 32'd0);
        chk_eq("t2_accepts_le_depth", 32'(n_accepts <= DEPTH), 32'd1);
        n_pops = 0;
        repeat (4) step(1'b0, 1'b0, 32'h0);
        chk_eq("t2_release_pops", 32'(n_pops), 32'd4);

        // Three outstanding at latency 5, then redirect
        drain();
        lat = 5;
        n_accepts = 0;
        repeat (3) step(1'b0, 1'b0, 32'h0);
        chk_eq("t3_outstanding", 32'(n_accepts), 32'd3);
        arm_first = 1'b1;
        first_pc = 32'hDEAD_BEEF;
        step(1'b0, 1'b1, 32'h0000_0100);
        repeat (25) step(1'b0, 1'b0, 32'h0);
        chk_eq("t3_first_pc", first_pc, 32'h0000_0100);

        // Redirect table: alignment and wrap of the address sequence
        for (int i = 0; i < 4; i++) begin
            lat = vecs[i].lat;
            step(1'b0, 1'b1, vecs[i].target);
            acc_log.delete();
            step(1'b0, 1'b0, 32'h0);
            chk_eq("tv_req_after", 32'(s_req), 32'd1);
            chk_eq("tv_addr_after", s_addr, vecs[i].e0);
            k = 0;
            while (acc_log.size() < 3 && k < 40) begin
                step(1'b0, 1'b0, 32'h0);
                k++;
            end
            if (acc_log.size() < 3) begin
                n_checks++;
                n_errors++;
                $display("FAIL tv_accept_timeout: got %0d accepts expected 3", acc_log.size());
            end else begin
                chk_eq("tv_addr0", acc_log[0], vecs[i].e0);
                chk_eq("tv_addr1", acc_log[1], vecs[i].e1);
                chk_eq("tv_addr2", acc_log[2], vecs[i].e2);
            end
            repeat (12) step($urandom_range(0, 3) == 0, 1'b0, 32'h0);
        end

        // Redirect in a cycle carrying a response while an instruction is presented
        lat = 2;
        repeat (8) step(1'b0, 1'b0, 32'h0);
        arm_first = 1'b1;
        first_pc = 32'hDEAD_BEEF;
        step(1'b0, 1'b1, 32'h0000_0400);
        step(1'b0, 1'b0, 32'h0);
        chk_eq("t5_empty_after", 32'(s_valid), 32'd0);
        repeat (15) step(1'b0, 1'b0, 32'h0);
        chk_eq("t5_first_pc", first_pc, 32'h0000_0400);

        // Random grant, stall and redirect traffic
        rand_gnt = 1'b1;
        lat = 3;
        repeat (80) begin
            if ($urandom_range(0, 11) == 0)
                step(1'b0, 1'b1, $urandom());
            else
                step($urandom_range(0, 2) == 0, 1'b0, 32'h0);
        end
        rand_gnt = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
